demux8_scheduler: RTL and testbench

Sequencing controller for the 1-to-8 demultiplexer (`oneto8demux`). It accepts words from a single upstream source over a valid/ready handshake and buffers one word at a time. It chooses a destination among the eight outputs by round-robin over the enabled and ready sinks, then drives the demux `a`/`en`/`sel` inputs for exactly one cycle per word. Words with no eligible sink are dropped after a programmable timeout.

---
 rtl/demux8_scheduler.sv | 125 ++++++++++++
 tb/tb_demux8_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/demux8_scheduler.sv
// Sequencing controller for the 1-to-8 demux: buffers one upstream word, picks a sink by
// round-robin over enabled+ready destinations, and drives a/en/sel for one cycle per word.
module demux8_scheduler #(
  parameter int W       = 1,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic [7:0]   dst_mask,
  input  logic [7:0]   dst_ready,
  output logic [W-1:0] a,
  output logic         en,
  output logic [2:0]   sel,
  output logic         drop,
  output logic [15:0]  delivered
);

  typedef enum logic [1:0] {IDLE, HOLD, DRIVE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   buf_q, buf_d;
  logic [7:0]     wait_q, wait_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [2:0]     sel_q, sel_d;
  logic [W-1:0]   a_q, a_d;
  logic           en_q, en_d;
  logic [15:0]    delivered_q, delivered_d;

  logic [7:0]     eligible;
  logic           found;
  logic [2:0]     winner;
  logic [2:0]     rr_idx;
  logic           drop_c;

  // Round-robin search starting at ptr; the lowest offset from ptr wins.
  always_comb begin
    eligible = dst_mask & dst_ready;
    found    = 1'b0;
    winner   = 3'd0;
    rr_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      rr_idx = ptr_q + 3'(i);
      if (!found && eligible[rr_idx]) begin
        found  = 1'b1;
        winner = rr_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    wait_d      = wait_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    a_d         = a_q;
    en_d        = 1'b0;
    delivered_d = delivered_q;
    drop_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = in_data;
          wait_d  = 8'd0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (found) begin
          sel_d   = winner;
          a_d     = buf_q;
          en_d    = 1'b1;
          state_d = DRIVE;
        end else if (wait_q == WAIT_LAST) begin
          drop_c  = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DRIVE: begin
        ptr_d       = sel_q + 3'd1;
        delivered_d = delivered_q + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      wait_q      <= 8'd0;
      ptr_q       <= 3'd0;
      sel_q       <= 3'd0;
      a_q         <= '0;
      en_q        <= 1'b0;
      delivered_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      wait_q      <= wait_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      a_q         <= a_d;
      en_q        <= en_d;
      delivered_q <= delivered_d;
    end
  end

  // Handshake and drop are combinational from state, masked while reset is asserted.
  assign in_ready  = (state_q == IDLE) & ~rst;
  assign drop      = drop_c & ~rst;
  assign a         = a_q;
  assign en        = en_q;
  assign sel       = sel_q;
  assign delivered = delivered_q;

endmodule

// File: tb/tb_demux8_scheduler.sv
// Directed, table-driven bench for demux8_scheduler: round-robin order, masking with wrap,
// ready gating, timeout drop and reset during DRIVE.
module tb_demux8_scheduler;

  localparam int W       = 1;
  localparam int TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [7:0]   dst_mask;
  logic [7:0]   dst_ready;
  logic [W-1:0] a;
  logic         en;
  logic [2:0]   sel;
  logic         drop;
  logic [15:0]  delivered;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0]   mask;
    logic [7:0]   ready;
    logic [W-1:0] data;
    logic [2:0]   exp_sel;
    logic [15:0]  exp_delivered;
  } vec_t;

  vec_t vecs[14];
  vec_t v;

  always #5 clk = ~clk;

  demux8_scheduler #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .dst_mask  (dst_mask),
    .dst_ready (dst_ready),
    .a         (a),
    .en        (en),
    .sel       (sel),
    .drop      (drop),
    .delivered (delivered)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] mask, input logic [7:0] ready,
                               input logic valid, input logic [W-1:0] data);
    dst_mask  = mask;
    dst_ready = ready;
    in_valid  = valid;
    in_data   = data;
  endtask

  // Entered just after a negedge while the DUT is in IDLE; returns in the following IDLE cycle.
  task automatic deliverWord(input vec_t w, input string tag);
    applyStimulus(w.mask, w.ready, 1'b1, w.data);
    #1 checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(w.mask, w.ready, 1'b0, '0);
    #1 checkOutput({tag, " en_hold"}, 32'(en), 32'd0);
    @(negedge clk);
    #1;
    checkOutput({tag, " en_drive"}, 32'(en), 32'd1);
    checkOutput({tag, " sel"}, 32'(sel), 32'(w.exp_sel));
    checkOutput({tag, " a"}, 32'(a), 32'(w.data));
    @(negedge clk);
    #1;
    checkOutput({tag, " en_after"}, 32'(en), 32'd0);
    checkOutput({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
    checkOutput({tag, " delivered"}, 32'(delivered), 32'(w.exp_delivered));
  endtask

  initial begin
    vecs = '{
      '{8'hFF, 8'hFF, 1'b1, 3'd0, 16'd1},
      '{8'hFF, 8'hFF, 1'b0, 3'd1, 16'd2},
      '{8'hFF, 8'hFF, 1'b1, 3'd2, 16'd3},
      '{8'hFF, 8'hFF, 1'b0, 3'd3, 16'd4},
      '{8'hFF, 8'hFF, 1'b1, 3'd4, 16'd5},
      '{8'hFF, 8'hFF, 1'b0, 3'd5, 16'd6},
      '{8'hFF, 8'hFF, 1'b1, 3'd6, 16'd7},
      '{8'hFF, 8'hFF, 1'b0, 3'd7, 16'd8},
      '{8'hFF, 8'hFF, 1'b1, 3'd0, 16'd9},
      '{8'hFF, 8'hFF, 1'b0, 3'd1, 16'd10},
      '{8'hFF, 8'hFF, 1'b1, 3'd2, 16'd11},
      '{8'h84, 8'hFF, 1'b1, 3'd7, 16'd12},
      '{8'h84, 8'hFF, 1'b0, 3'd2, 16'd13},
      '{8'h84, 8'hFF, 1'b1, 3'd7, 16'd14}
    };

    rst = 1'b1;
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checkOutput("rst in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst en", 32'(en), 32'd0);
      checkOutput("rst sel", 32'(sel), 32'd0);
      checkOutput("rst delivered", 32'(delivered), 32'd0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1 checkOutput("release in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 14; i++) deliverWord(vecs[i], $sformatf("vec%0d", i));

    // Ready gating: nothing ready for five HOLD cycles, then only sink 4.
    applyStimulus(8'hFF, 8'h00, 1'b1, 1'b1);
    #1 checkOutput("gate in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      checkOutput($sformatf("gate drop h%0d", k), 32'(drop), 32'd0);
      checkOutput($sformatf("gate en h%0d", k), 32'(en), 32'd0);
    end
    @(posedge clk);
    #1 dst_ready = 8'h10;
    @(negedge clk);
    #1;
    checkOutput("gate drop h6", 32'(drop), 32'd0);
    checkOutput("gate en h6", 32'(en), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("gate en drive", 32'(en), 32'd1);
    checkOutput("gate sel", 32'(sel), 32'd4);
    checkOutput("gate drop drive", 32'(drop), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("gate en after", 32'(en), 32'd0);
    checkOutput("gate delivered", 32'(delivered), 32'd15);

    // Timeout: no enabled sink, the word must be dropped in cycle N+TIMEOUT.
    applyStimulus(8'h00, 8'hFF, 1'b1, 1'b0);
    #1 checkOutput("to in_ready", 32'(in_ready), 32'd1);
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("to en c%0d", k), 32'(en), 32'd0);
      checkOutput($sformatf("to drop c%0d", k), 32'(drop), (k == TIMEOUT) ? 32'd1 : 32'd0);
      if (k <= TIMEOUT) checkOutput($sformatf("to in_ready c%0d", k), 32'(in_ready), 32'd0);
    end
    checkOutput("to in_ready idle", 32'(in_ready), 32'd1);
    checkOutput("to delivered", 32'(delivered), 32'd15);
    checkOutput("to sel held", 32'(sel), 32'd4);
    v = '{8'hFF, 8'hFF, 1'b1, 3'd5, 16'd16};
    deliverWord(v, "after_drop");

    // Reset asserted in the DRIVE cycle.
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1);
    #1 checkOutput("mr in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("mr en drive", 32'(en), 32'd1);
    checkOutput("mr sel drive", 32'(sel), 32'd6);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("mr en", 32'(en), 32'd0);
    checkOutput("mr drop", 32'(drop), 32'd0);
    checkOutput("mr in_ready", 32'(in_ready), 32'd0);
    checkOutput("mr delivered", 32'(delivered), 32'd0);
    rst = 1'b0;
    #1 checkOutput("mr release in_ready", 32'(in_ready), 32'd1);
    v = '{8'hFF, 8'hFF, 1'b0, 3'd0, 16'd1};
    deliverWord(v, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
